axis_m_pkt: RTL and testbench
=============================

# axis_m_pkt

AXI-Stream packet master that sits directly upstream of the stream slave (`axis_s`) and drives its `tvalid`/`tdata`/`tlast` inputs. User logic pushes words into an internal FIFO and requests a packet of N beats. The block then streams exactly N beats with `tlast` on the final beat, and pulses `finish` when that beat has handshaken. It must sustain full AXI-Stream handshake rules against a slave that drops `tready` after every beat.

## Interface
- `DATA_WIDTH`, 32, data bus width.
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥2.
- `LEN_WIDTH`, 8, width of packet length field.

- `aclk` in 1: single clock, all logic on rising edge.
- `areset_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: push `wr_data` into FIFO; ignored when `full`.
- `wr_data` in DATA_WIDTH: word to push.
- `full` out 1: FIFO holds FIFO_DEPTH words.
- `level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `start` in 1: request packet; accepted only in IDLE with `pkt_len`≠0.
- `pkt_len` in LEN_WIDTH: beats in packet (1..2^LEN_WIDTH−1).
- `busy` out 1: high in SEND and DONE.
- `tvalid` out 1, `tready` in 1, `tdata` out DATA_WIDTH, `tlast` out 1: AXI-Stream master side.
- `finish` out 1: one-cycle pulse after last beat handshakes.

## Operation
- FSM states: IDLE, SEND, DONE.
  - IDLE → SEND when `start` is high and `pkt_len`≠0; latch `pkt_len` into `remaining`.
  - SEND → DONE on handshake (`tvalid & tready`) of the beat with `tlast`=1.
  - DONE → IDLE unconditionally after one cycle; `finish`=1 only in DONE.
- `start` is ignored outside IDLE or when `pkt_len`=0.
- FIFO:
  - Pointers of width $clog2(FIFO_DEPTH) wrap naturally; a separate count drives `full`/`level`.
  - Writes are accepted in any state, including IDLE (prefill is allowed).
  - A write when `full` is dropped, even if a read occurs in the same cycle.
  - A simultaneous read and write when not full leaves `level` unchanged.
- Output register (holds `tvalid`/`tdata`/`tlast`):
  - Load condition: state is SEND, `remaining`≠0, FIFO is non-empty, and the register is empty or handshaking this cycle.
  - On load: pop the FIFO, set `tvalid`=1, set `tlast`=(`remaining`==1), and decrement `remaining`.
  - On a handshake with no reload, `tvalid` clears.
- AXI rules:
  - `tvalid` never depends combinationally on `tready`.
  - Once `tvalid` is high, `tdata`/`tlast` are held until handshake.
- FIFO underrun mid-packet: `tvalid` goes low and the packet stalls until data arrives; no error flag.
- Words beyond `pkt_len` stay in the FIFO for the next packet.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `tlast`=0, `finish`=0, `busy`=0, `full`=0, `level`=0, state=IDLE; FIFO pointers and `remaining` cleared.
- Reset asserted mid-packet aborts immediately and flushes FIFO contents.
- `start` sampled at edge s with FIFO non-empty: first `tvalid` high after edge s+1.
- FIFO write at edge k while in SEND with the output register empty: `tvalid` high after edge k+1.
- Throughput: one beat per cycle while `tready` is held high and the FIFO is non-empty.
- `finish` is high for exactly the cycle after the `tlast` handshake edge.
- `busy` falls one cycle after that.

## Configuration
- `AXIS_M_PKT_CNT_EN`:
  - Defined: adds output `pkt_cnt` [15:0], which increments on entry to DONE, wraps 0xFFFF→0, and resets to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Prefill 4 words (0xA0..0xA3); `start` with `pkt_len`=4; `tready`=1 → 4 consecutive beats 0xA0..0xA3, `tlast` only on 0xA3, `finish` pulse 1 cycle later, `level`=0.
- Same packet into a slave that drops `tready` after each beat → data stable while `tready`=0, exactly 4 handshakes, no duplicated or lost words.
- Write 9 words with FIFO_DEPTH=8 and no `start` → `full`=1 after 8 writes, 9th word dropped, `level`=8.
- `pkt_len`=3 with only 1 word in the FIFO → beat 1 sent, `tvalid`=0 stall; 2 more writes → beats 2–3 sent, `tlast` on the 3rd.
- `start` asserted during SEND, and `start` with `pkt_len`=0 in IDLE → both ignored, packet length unchanged.
- `areset_n` low mid-packet after 2 of 5 beats → all outputs at reset values asynchronously, `level`=0; a new 2-beat packet after release completes normally (with `AXIS_M_PKT_CNT_EN` defined, `pkt_cnt`=1).

Source files
------------

// File: rtl/axis_m_pkt.sv
// rtl/axis_m_pkt.sv - AXI-Stream packet master: FIFO-fed, N-beat packets with tlast and finish pulse
// Optional AXIS_M_PKT_CNT_EN adds a 16-bit completed-packet counter output pkt_cnt.

module axis_m_pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic                       push_en,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_en,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A write while full is dropped even if a pop frees a slot this same cycle
  assign push     = push_en & ~full;
  assign pop      = pop_en & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_L);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module axis_m_pkt #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          pkt_len,
  output logic                          busy,
  output logic                          tvalid,
  input  logic                          tready,
  output logic [DATA_WIDTH-1:0]         tdata,
  output logic                          tlast,
  output logic                          finish
`ifdef AXIS_M_PKT_CNT_EN
  ,
  output logic [15:0]                   pkt_cnt
`endif
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  start_ok;
  logic                  hs;
  logic                  load;

  axis_m_pkt_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .push_en   (wr_en),
    .push_data (wr_data),
    .pop_en    (load),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (full),
    .level     (level)
  );

  assign start_ok = start && (pkt_len != '0);
  assign hs       = tvalid & tready;
  // Reload whenever the output slot is free or draining this cycle; tready only gates the load
  assign load     = (state == S_SEND) && (remaining != '0) && !fifo_empty && (!tvalid || tready);
  assign busy     = (state != S_IDLE);
  assign finish   = (state == S_DONE);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_SEND;
      S_SEND:  if (hs && tlast) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      remaining <= '0;
    end else if ((state == S_IDLE) && start_ok) begin
      remaining <= pkt_len;
    end else if (load) begin
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= fifo_data;
      tlast  <= (remaining == LEN_WIDTH'(1));
    end else if (hs) begin
      tvalid <= 1'b0;
    end
  end

`ifdef AXIS_M_PKT_CNT_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      pkt_cnt <= '0;
    end else if ((state == S_SEND) && (state_nxt == S_DONE)) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axis_m_pkt.sv
// tb/tb_axis_m_pkt.sv - self-checking bench for axis_m_pkt: vector table, corner sequences, random vs queue model

module tb_axis_m_pkt;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 8;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          tready = 1'b0;
  logic          full, busy, tvalid, tlast, finish;
  logic [3:0]    level;
  logic [DW-1:0] tdata;
`ifdef AXIS_M_PKT_CNT_EN
  logic [15:0]   pkt_cnt;
`endif

  axis_m_pkt #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .start    (start),
    .pkt_len  (pkt_len),
    .busy     (busy),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast),
    .finish   (finish)
`ifdef AXIS_M_PKT_CNT_EN
    ,
    .pkt_cnt  (pkt_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int last_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: packet phase, beats still owed, a word queue and the presented beat
  logic [DW-1:0] m_q[$];
  int            m_phase;
  int            m_rem;
  bit            m_valid;
  bit            m_last;
  logic [DW-1:0] m_data;
  int            m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_rem   = 0;
    m_valid = 0;
    m_last  = 0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    bit hs_now   = m_valid && tready;
    bit last_now = m_last;
    bit ld       = (m_phase == 1) && (m_rem > 0) && (m_q.size() > 0) && (!m_valid || tready);
    bit acc      = wr_en && (m_q.size() < DEPTH);
    if (ld) begin
      m_data  = m_q.pop_front();
      m_last  = (m_rem == 1);
      m_rem   = m_rem - 1;
      m_valid = 1;
    end else if (hs_now) begin
      m_valid = 0;
    end
    if (acc) m_q.push_back(wr_data);
    case (m_phase)
      0: if (start && pkt_len != 0) begin m_phase = 1; m_rem = int'(pkt_len); end
      1: if (hs_now && last_now) begin m_phase = 2; m_cnt = (m_cnt + 1) & 16'hFFFF; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic model_cmp();
    chk("tvalid", tvalid, m_valid);
    if (m_valid) begin
      chk("tdata", tdata, m_data);
      chk("tlast", tlast, m_last);
    end
    chk("level", level, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("busy", busy, m_phase != 0);
    chk("finish", finish, m_phase == 2);
`ifdef AXIS_M_PKT_CNT_EN
    chk("pkt_cnt", pkt_cnt, m_cnt);
`endif
  endtask

  // Inputs are set at a falling edge before calling; outputs checked at the next falling edge
  task automatic tick();
    if (tvalid && tready) begin
      hs_cnt++;
      if (tlast) last_cnt++;
    end
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    model_cmp();
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_pkt(input int len);
    start   = 1'b1;
    pkt_len = LW'(len);
    tick();
    start   = 1'b0;
    pkt_len = '0;
  endtask

  task automatic run_until_finish(input string nm);
    int c = 0;
    while (!finish && c < 50) begin
      tick();
      c++;
    end
    chk({nm, "_finish"}, finish, 1'b1);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; start = 1'b0; tready = 1'b0; pkt_len = '0;
    areset_n = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    model_reset();
    hs_cnt = 0;
    last_cnt = 0;
  endtask

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          st;
    logic [LW-1:0] len;
    logic          rdy;
    logic [3:0]    lvl;
    logic          fl;
    logic          vld;
    logic [DW-1:0] dat;
    logic          lst;
    logic          fin;
    logic          bsy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit wr, int wd, bit st, int len, bit rdy, int lvl, bit fl,
                              bit vld, int dat, bit lst, bit fin, bit bsy);
    vec_t v;
    v.wr = wr;  v.wd = DW'(wd); v.st = st; v.len = LW'(len); v.rdy = rdy;
    v.lvl = 4'(lvl); v.fl = fl; v.vld = vld; v.dat = DW'(dat); v.lst = lst;
    v.fin = fin; v.bsy = bsy;
    return v;
  endfunction

  initial begin
    logic          prev_v, prev_r;
    logic [DW-1:0] prev_d;

    // Prefill 0xA0..0xA3, 4-beat packet at full rate, then overfill the FIFO with 9 writes
    for (int i = 0; i < 4; i++) vt.push_back(mk(1, 'hA0 + i, 0, 0, 1, i + 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 4, 1, 4, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0, 0, 0, 0, 1, 3 - i, 0, 1, 'hA0 + i, i == 3, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      vt.push_back(mk(1, 'h100 + i, 0, 0, 0, (i < 8) ? i + 1 : 8, i >= 7, 0, 0, 0, 0, 0));

    model_reset();
    areset_n = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 4'd0);
    areset_n = 1'b1;

    foreach (vt[i]) begin
      wr_en = vt[i].wr; wr_data = vt[i].wd; start = vt[i].st; pkt_len = vt[i].len; tready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_level", i), level, vt[i].lvl);
      chk($sformatf("vec%0d_full", i), full, vt[i].fl);
      chk($sformatf("vec%0d_tvalid", i), tvalid, vt[i].vld);
      if (vt[i].vld) begin
        chk($sformatf("vec%0d_tdata", i), tdata, vt[i].dat);
        chk($sformatf("vec%0d_tlast", i), tlast, vt[i].lst);
      end
      chk($sformatf("vec%0d_finish", i), finish, vt[i].fin);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
    end

    // Slave that drops tready after every beat
    do_reset();
    push_words(4, 32'hA0);
    start_pkt(4);
    for (int c = 0; c < 40 && !finish; c++) begin
      tready = ~tready;
      prev_v = tvalid; prev_d = tdata; prev_r = tready;
      tick();
      if (prev_v && !prev_r) chk("hold_tdata", tdata, prev_d);
    end
    chk("drop_finish", finish, 1'b1);
    chk("drop_hs", hs_cnt, 4);
    chk("drop_tlast", last_cnt, 1);
    tick();

    // Underrun: one word for a 3-beat packet, then two late writes
    do_reset();
    tready = 1'b1;
    push_words(1, 32'hC0);
    start_pkt(3);
    repeat (3) tick();
    chk("underrun_stall", tvalid, 1'b0);
    chk("underrun_busy", busy, 1'b1);
    push_words(2, 32'hC1);
    run_until_finish("underrun");
    chk("underrun_hs", hs_cnt, 3);
    chk("underrun_tlast", last_cnt, 1);

    // start during SEND and start with pkt_len=0 are both ignored
    do_reset();
    push_words(6, 32'hD0);
    start_pkt(4);
    tick();
    start_pkt(2);
    tready = 1'b1;
    run_until_finish("restart");
    chk("restart_hs", hs_cnt, 4);
    tick();
    tick();
    start_pkt(0);
    tick();
    chk("len0_busy", busy, 1'b0);
    chk("len0_level", level, 4'd2);

    // Asynchronous reset after 2 of 5 beats, then a fresh 2-beat packet
    do_reset();
    push_words(5, 32'hF0);
    start_pkt(5);
    tready = 1'b1;
    for (int c = 0; c < 20 && hs_cnt < 2; c++) tick();
    #2 areset_n = 1'b0;
    #1;
    chk("arst_tvalid", tvalid, 1'b0);
    chk("arst_tdata", tdata, '0);
    chk("arst_tlast", tlast, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_finish", finish, 1'b0);
    chk("arst_level", level, 4'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    model_reset();
    hs_cnt = 0;
    push_words(2, 32'hB0);
    start_pkt(2);
    run_until_finish("after_rst");
    chk("after_rst_hs", hs_cnt, 2);
`ifdef AXIS_M_PKT_CNT_EN
    chk("after_rst_pkt_cnt", pkt_cnt, 16'd1);
`endif
    tick();

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ((c / 500) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      wr_data = $urandom;
      start   = ($urandom % 6 == 0);
      pkt_len = LW'($urandom_range(0, 7));
      tready  = ($urandom % 4 != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
